// File: rtl/encoder_rr.sv
// encoder_rr: round-robin multi-hot to binary index encoder with registered valid/ready output and one-hot grant ack
// Optional strict one-hot error flag is built when ENCODER_ONEHOT_CHK_EN is defined
module encoder_rr #(
    parameter int NUM_ENTRY     = 8,
    parameter int LOG_NUM_ENTRY = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_ENTRY-1:0]     I_Req,
    input  logic                     I_Rdy,
    output logic [LOG_NUM_ENTRY-1:0] O_Val,
    output logic                     O_Valid,
    output logic [NUM_ENTRY-1:0]     O_Grt,
    output logic                     O_Err
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    state_t                   r_state, w_next;
    logic [LOG_NUM_ENTRY-1:0] r_val, r_ptr, w_sel, w_ptr_nxt;
    logic [NUM_ENTRY-1:0]     r_grt, w_elig;
    logic                     w_cap;
    assign w_elig    = I_Req & ~r_grt;
    assign w_cap     = (|w_elig) & (~O_Valid | I_Rdy);
    assign w_ptr_nxt = (w_sel == LOG_NUM_ENTRY'(NUM_ENTRY - 1)) ? '0 : w_sel + 1'b1;
    assign O_Val     = r_val;
    assign O_Grt     = r_grt;
    // rotated search from r_ptr; scanning offsets downward lets the smallest offset win
    always_comb begin
        w_sel = '0;
        for (int k = NUM_ENTRY - 1; k >= 0; k--)
            if (w_elig[(int'(r_ptr) + k) % NUM_ENTRY]) w_sel = LOG_NUM_ENTRY'((int'(r_ptr) + k) % NUM_ENTRY);
    end
    // FSM state register
    always_ff @(posedge clock)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    // FSM next state: leave HOLD only when the result is taken with nothing left to load
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_cap ? HOLD : IDLE;
        else w_next = (I_Rdy && !(|w_elig)) ? IDLE : HOLD;
    end
    // FSM output: valid mirrors the HOLD state
    always_comb O_Valid = (r_state == HOLD);
    // datapath: load index, advance pointer and pulse the ack on capture
    always_ff @(posedge clock)
        if (reset) begin
            r_val <= '0;
            r_ptr <= '0;
            r_grt <= '0;
        end else if (w_cap) begin
            r_val <= w_sel;
            r_ptr <= w_ptr_nxt;
            r_grt <= NUM_ENTRY'(1) << w_sel;
        end else begin
            r_grt <= '0;
        end
`ifdef ENCODER_ONEHOT_CHK_EN
    logic r_err;
    // sticky flag for a capture that saw more than one eligible request
    always_ff @(posedge clock)
        if (reset) r_err <= 1'b0;
        else if (w_cap && $countones(w_elig) > 1) r_err <= 1'b1;
    assign O_Err = r_err;
`else
    assign O_Err = 1'b0;
`endif
endmodule

// File: tb/tb_encoder_rr.sv
// tb_encoder_rr: directed self-checking bench for encoder_rr
module tb_encoder_rr;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req   = '0;
    logic       rdy   = 1'b0;
    logic [2:0] val;
    logic       valid;
    logic [7:0] grt;
    logic       err;
    int         n_pass  = 0;
    int         n_total = 0;
`ifdef ENCODER_ONEHOT_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    encoder_rr #(.NUM_ENTRY(8), .LOG_NUM_ENTRY(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .I_Req  (req),
        .I_Rdy  (rdy),
        .O_Val  (val),
        .O_Valid(valid),
        .O_Grt  (grt),
        .O_Err  (err)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        rdy   = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        step();
        n_total++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else n_pass++;
        n_total++; if (val !== 3'd0) $display("FAIL rst_val got %0d exp 0", val); else n_pass++;
        n_total++; if (grt !== 8'h00) $display("FAIL rst_grt got %h exp 00", grt); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (valid !== 1'b0 || grt !== 8'h00 || val !== 3'd0)
                $display("FAIL idle_%0d got valid=%b grt=%h val=%0d exp 0/00/0", i, valid, grt, val);
            else n_pass++;
        end
    endtask

    task automatic test_single;
        do_reset();
        req = 8'h10;
        rdy = 1'b1;
        step();
        n_total++; if (val !== 3'd4) $display("FAIL single_val got %0d exp 4", val); else n_pass++;
        n_total++; if (valid !== 1'b1) $display("FAIL single_valid got %b exp 1", valid); else n_pass++;
        n_total++; if (grt !== 8'h10) $display("FAIL single_grt got %h exp 10", grt); else n_pass++;
        step();
        n_total++; if (valid !== 1'b0) $display("FAIL mask_valid got %b exp 0", valid); else n_pass++;
        n_total++; if (grt !== 8'h00) $display("FAIL mask_grt got %h exp 00", grt); else n_pass++;
        req = 8'h00;
        step();
        n_total++; if (valid !== 1'b0 || grt !== 8'h00) $display("FAIL drop got valid=%b grt=%h exp 0/00", valid, grt); else n_pass++;
        n_total++; if (val !== 3'd4) $display("FAIL drop_val_hold got %0d exp 4", val); else n_pass++;
    endtask

    task automatic test_wrap;
        do_reset();
        req = 8'hFF;
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] e;
            logic [7:0] g;
            e = 3'(i % 8);
            g = 8'h01 << e;
            step();
            n_total++; if (val !== e || grt !== g || valid !== 1'b1)
                $display("FAIL wrap_%0d got val=%0d grt=%h valid=%b exp %0d/%h/1", i, val, grt, valid, e, g);
            else n_pass++;
        end
        req = 8'h00;
        step();
        n_total++; if (valid !== 1'b0) $display("FAIL wrap_end_valid got %b exp 0", valid); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_reset();
        req = 8'h81;
        rdy = 1'b0;
        step();
        n_total++; if (val !== 3'd0 || grt !== 8'h01 || valid !== 1'b1)
            $display("FAIL bp_first got val=%0d grt=%h valid=%b exp 0/01/1", val, grt, valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (val !== 3'd0 || grt !== 8'h00 || valid !== 1'b1)
                $display("FAIL bp_hold_%0d got val=%0d grt=%h valid=%b exp 0/00/1", i, val, grt, valid);
            else n_pass++;
        end
        rdy = 1'b1;
        step();
        n_total++; if (val !== 3'd7 || grt !== 8'h80 || valid !== 1'b1)
            $display("FAIL bp_release got val=%0d grt=%h valid=%b exp 7/80/1", val, grt, valid);
        else n_pass++;
        req = 8'h00;
        step();
        n_total++; if (valid !== 1'b0) $display("FAIL bp_end_valid got %b exp 0", valid); else n_pass++;
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 8'h02;
        rdy = 1'b0;
        step();
        n_total++; if (val !== 3'd1 || valid !== 1'b1) $display("FAIL mr_pre got val=%0d valid=%b exp 1/1", val, valid); else n_pass++;
        req = 8'h00;
        step();
        reset = 1'b1;
        step();
        n_total++; if (valid !== 1'b0 || val !== 3'd0 || grt !== 8'h00)
            $display("FAIL mr_reset got valid=%b val=%0d grt=%h exp 0/0/00", valid, val, grt);
        else n_pass++;
        reset = 1'b0;
        req   = 8'h06;
        rdy   = 1'b1;
        step();
        n_total++; if (val !== 3'd1 || grt !== 8'h02) $display("FAIL mr_ptr got val=%0d grt=%h exp 1/02", val, grt); else n_pass++;
        req = 8'h00;
        step();
    endtask

    task automatic test_onehot_err;
        do_reset();
        req = 8'h06;
        rdy = 1'b1;
        step();
        n_total++; if (val !== 3'd1) $display("FAIL err_val got %0d exp 1", val); else n_pass++;
        n_total++; if (err !== EXP_ERR) $display("FAIL err_set got %b exp %b", err, EXP_ERR); else n_pass++;
        step();
        n_total++; if (val !== 3'd2 || grt !== 8'h04) $display("FAIL err_next got val=%0d grt=%h exp 2/04", val, grt); else n_pass++;
        req = 8'h00;
        step();
        step();
        n_total++; if (err !== EXP_ERR) $display("FAIL err_sticky got %b exp %b", err, EXP_ERR); else n_pass++;
        reset = 1'b1;
        step();
        n_total++; if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err); else n_pass++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_mid_reset();
        test_onehot_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
